// File: rtl/timer_irq_ctrl_pkg.sv
// rtl/timer_irq_ctrl_pkg.sv - shared register map, bit positions and FSM encoding
//
// Purpose : constants and types shared by timer_irq_ctrl and its sub-module.
// Ports   : none (package).
package timer_irq_ctrl_pkg;

  // Register offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  // STATUS bit positions
  localparam int STAT_PEND_BIT   = 0;
  localparam int STAT_OVR_BIT    = 1;
  localparam int STAT_MISSED_LSB = 8;

  // Width of the settle countdown (holds SETTLE_CYCLES up to 3)
  localparam int SETTLE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONSUME = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_irq_ctrl_sat_counter.sv
// rtl/timer_irq_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose : counts inc pulses, sticks at all-ones, clr has priority over inc.
// Ports   : CLK, RST (async active-high), i_en (global write enable),
//           i_inc, i_clr, o_q [W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_en,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = (r_q == {W{1'b1}});
  assign o_q      = r_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_q <= '0;
      end else if (i_inc && !w_at_max) begin
        r_q <= r_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer expiry consumer with pending/overrun interrupt latch
//
// Purpose : consumes timer expiries (status_in), pulses read_status to re-arm
//           the timer, latches a pending interrupt and counts missed expiries.
// Ports   : CLK, RST (async active-high), GWE (global write enable),
//           status_in (timer expiry flag), read_status (re-arm pulse),
//           reg_we/reg_re/reg_addr[1:0]/reg_wdata[15:0]/reg_rdata[15:0]
//           (register port, rdata combinational), irq_ack, irq.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int MISSED_W      = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        GWE,
  input  logic        status_in,
  output logic        read_status,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [1:0]  reg_addr,
  input  logic [15:0] reg_wdata,
  output logic [15:0] reg_rdata,
  input  logic        irq_ack,
  output logic        irq
);

  state_t                r_state;
  state_t                w_state_next;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [SETTLE_W-1:0]   w_settle_next;
  logic                  w_event;

  logic [1:0]            r_ctrl;
  logic [1:0]            w_ctrl_next;
  logic                  r_pend;
  logic                  w_pend_next;
  logic                  r_ovr;
  logic                  w_ovr_next;
  logic                  r_irq;

  logic                  w_ctrl_wr;
  logic                  w_stat_wr;
  logic                  w_clr_pend;
  logic                  w_clr_ovr;
  logic                  w_miss;
  logic [MISSED_W-1:0]   w_missed;
  logic [15:0]           w_status;
  logic                  w_unused;

  assign w_unused = ^reg_wdata[15:2];

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
    end else if (GWE) begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_event       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_EN_BIT] && status_in) begin
          w_state_next = ST_CONSUME;
        end
      end
      ST_CONSUME: begin
        // The expiry is recorded on the edge leaving CONSUME, so a reset
        // during the read_status pulse never records an event.
        w_event       = 1'b1;
        w_state_next  = ST_SETTLE;
        w_settle_next = SETTLE_W'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        // status_in may still show the old expiry right after reload;
        // it is ignored here so one CONSUME yields one event.
        w_settle_next = r_settle_cnt - SETTLE_W'(1);
        if (r_settle_cnt == SETTLE_W'(1)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign read_status = (r_state == ST_CONSUME);

  // ---------------- Registers ----------------
  assign w_ctrl_wr  = reg_we && (reg_addr == REG_CTRL);
  assign w_stat_wr  = reg_we && (reg_addr == REG_STATUS);
  assign w_clr_pend = irq_ack | (w_stat_wr & reg_wdata[STAT_PEND_BIT]);
  assign w_clr_ovr  = w_stat_wr & reg_wdata[STAT_OVR_BIT];

  // An event counts as missed only if pending survives this edge's clears;
  // a clear on the same edge behaves as clear-then-set.
  assign w_miss      = w_event & r_pend & ~w_clr_pend;
  assign w_pend_next = w_event | (r_pend & ~w_clr_pend);
  assign w_ovr_next  = w_clr_ovr ? 1'b0 : (r_ovr | w_miss);
  assign w_ctrl_next = w_ctrl_wr ? reg_wdata[CTRL_IE_BIT:CTRL_EN_BIT] : r_ctrl;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ctrl <= '0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
      r_irq  <= 1'b0;
    end else if (GWE) begin
      r_ctrl <= w_ctrl_next;
      r_pend <= w_pend_next;
      r_ovr  <= w_ovr_next;
      r_irq  <= w_pend_next & w_ctrl_next[CTRL_IE_BIT];
    end
  end

  sat_counter #(
    .W (MISSED_W)
  ) u_missed (
    .CLK   (CLK),
    .RST   (RST),
    .i_en  (GWE),
    .i_inc (w_miss),
    .i_clr (w_clr_ovr),
    .o_q   (w_missed)
  );

  assign irq = r_irq;

  // ---------------- Read mux ----------------
  always_comb begin
    w_status                                   = '0;
    w_status[STAT_PEND_BIT]                    = r_pend;
    w_status[STAT_OVR_BIT]                     = r_ovr;
    w_status[STAT_MISSED_LSB +: MISSED_W]      = w_missed;
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_re) begin
      case (reg_addr)
        REG_CTRL:   reg_rdata = {14'd0, r_ctrl};
        REG_STATUS: reg_rdata = w_status;
        default:    reg_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - self-checking bench for timer_irq_ctrl
module tb_timer_irq_ctrl;

  logic        CLK = 1'b0;
  logic        RST, GWE, status_in, reg_we, reg_re, irq_ack;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        rs0, rs1, irq0, irq1;
  logic [15:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  // instance 0: MISSED_W=8, SETTLE_CYCLES=1; instance 1: MISSED_W=2, SETTLE_CYCLES=3
  int m_settle[2];
  int m_max[2];
  int m_busy[2];   // cycles left in the consume+settle sequence (0 = idle)
  bit m_pend[2];
  bit m_ovr[2];
  int m_missed[2];
  bit [1:0] m_ctrl;

  always #5 CLK = ~CLK;

  timer_irq_ctrl #(.MISSED_W(8), .SETTLE_CYCLES(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .GWE(GWE), .status_in(status_in), .read_status(rs0),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(rd0), .irq_ack(irq_ack), .irq(irq0)
  );

  timer_irq_ctrl #(.MISSED_W(2), .SETTLE_CYCLES(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .GWE(GWE), .status_in(status_in), .read_status(rs1),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(rd1), .irq_ack(irq_ack), .irq(irq1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; m_missed[k] = 0;
    end
    m_ctrl = 2'b00;
  endtask

  function automatic logic [15:0] exp_rd(input int k);
    logic [15:0] v;
    logic [7:0]  mm;
    v  = 16'h0000;
    mm = 8'(m_missed[k]);
    if (reg_re) begin
      if (reg_addr == 2'd0)      v = {14'd0, m_ctrl};
      else if (reg_addr == 2'd1) v = {mm, 6'd0, m_ovr[k], m_pend[k]};
    end
    return v;
  endfunction

  // Applies the behavioural rules for one rising edge with the current inputs.
  task automatic model_edge();
    bit ev, clr_p, clr_o;
    if (!GWE) return;
    clr_p = irq_ack || (reg_we && reg_addr == 2'd1 && reg_wdata[0]);
    clr_o = reg_we && reg_addr == 2'd1 && reg_wdata[1];
    for (int k = 0; k < 2; k++) begin
      ev = (m_busy[k] == m_settle[k] + 1);
      if (m_busy[k] > 0) m_busy[k]--;
      else if (m_ctrl[0] && status_in) m_busy[k] = m_settle[k] + 1;
      if (clr_o) begin
        m_ovr[k] = 0; m_missed[k] = 0;
      end else if (ev && m_pend[k] && !clr_p) begin
        m_ovr[k] = 1;
        if (m_missed[k] < m_max[k]) m_missed[k]++;
      end
      if (ev) m_pend[k] = 1;
      else if (clr_p) m_pend[k] = 0;
    end
    if (reg_we && reg_addr == 2'd0) m_ctrl = reg_wdata[1:0];
  endtask

  task automatic check_outputs(input string tag);
    check($sformatf("%s.rs0", tag), {15'd0, rs0}, {15'd0, m_busy[0] == m_settle[0] + 1});
    check($sformatf("%s.rs1", tag), {15'd0, rs1}, {15'd0, m_busy[1] == m_settle[1] + 1});
    check($sformatf("%s.irq0", tag), {15'd0, irq0}, {15'd0, m_pend[0] & m_ctrl[1]});
    check($sformatf("%s.irq1", tag), {15'd0, irq1}, {15'd0, m_pend[1] & m_ctrl[1]});
    check($sformatf("%s.rd0", tag), rd0, exp_rd(0));
    check($sformatf("%s.rd1", tag), rd1, exp_rd(1));
  endtask

  task automatic cycle(input string tag);
    #1 check_outputs(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic pulse_expiry(input string tag, input int gap);
    status_in = 1'b1;
    cycle(tag);
    status_in = 1'b0;
    repeat (gap) cycle(tag);
  endtask

  task automatic write_reg(input string tag, input logic [1:0] a, input logic [15:0] d);
    logic [1:0] sa;
    sa = reg_addr;
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cycle(tag);
    reg_we = 1'b0; reg_addr = sa; reg_wdata = 16'h0000;
  endtask

  initial begin
    m_settle[0] = 1; m_settle[1] = 3;
    m_max[0] = 255; m_max[1] = 3;
    RST = 1'b1; GWE = 1'b1; status_in = 1'b1; reg_we = 1'b0; reg_re = 1'b1;
    reg_addr = 2'd1; reg_wdata = 16'h0000; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_outputs("reset");
    check("reset_status", rd0, 16'h0000);

    RST = 1'b0;
    repeat (6) cycle("en_off");          // status_in=1 but EN=0

    status_in = 1'b0;
    write_reg("wr_ctrl", 2'd0, 16'h0003);
    repeat (3) cycle("idle");
    pulse_expiry("first", 6);
    check("first_status", rd0, 16'h0001);
    check("first_irq", {15'd0, irq0}, 16'h0001);

    repeat (3) pulse_expiry("three", 5);
    check("three_status0", rd0, 16'h0303);
    check("three_status1", rd1, 16'h0303);
    write_reg("w1c_ovr", 2'd1, 16'h0002);
    check("w1c_ovr", rd0, 16'h0001);
    irq_ack = 1'b1; cycle("ack"); irq_ack = 1'b0;
    check("ack_status", rd0, 16'h0000);
    check("ack_irq", {15'd0, irq0}, 16'h0000);

    repeat (6) pulse_expiry("sat", 5);
    check("sat_status0", rd0, 16'h0503);
    check("sat_status1", rd1, 16'h0303);

    // expiry event on the same edge as irq_ack
    status_in = 1'b1; cycle("ev_ack_a");
    status_in = 1'b0; irq_ack = 1'b1; cycle("ev_ack_b"); irq_ack = 1'b0;
    check("ev_ack_status0", rd0, 16'h0503);
    check("ev_ack_irq0", {15'd0, irq0}, 16'h0001);
    repeat (4) cycle("ev_ack_c");

    // expiry event on the same edge as overrun clear
    status_in = 1'b1; cycle("ev_clr_a");
    status_in = 1'b0; write_reg("ev_clr_b", 2'd1, 16'h0002);
    check("ev_clr_status0", rd0, 16'h0001);
    repeat (4) cycle("ev_clr_c");

    // freeze during CONSUME, including an ignored register write
    status_in = 1'b1; cycle("gwe_a");
    status_in = 1'b0; GWE = 1'b0;
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 16'h0000;
    repeat (4) begin
      cycle("gwe_frozen");
      check("gwe_rs0", {15'd0, rs0}, 16'h0001);
    end
    reg_we = 1'b0; reg_addr = 2'd1; GWE = 1'b1;
    repeat (5) cycle("gwe_resume");

    // EN cleared mid-sequence lets the sequence finish
    status_in = 1'b1; cycle("en_clr_a");
    status_in = 1'b0; write_reg("en_clr_b", 2'd0, 16'h0002);
    status_in = 1'b1;
    repeat (8) cycle("en_clr_c");       // EN=0, status held: no pulses

    // reset while read_status is high
    write_reg("rst_en", 2'd0, 16'h0003);
    cycle("rst_a");
    check("rst_consume", {15'd0, rs0}, 16'h0001);
    #1 RST = 1'b1;
    #1;
    check("rst_async_rs0", {15'd0, rs0}, 16'h0000);
    check("rst_async_irq0", {15'd0, irq0}, 16'h0000);
    model_reset();
    @(negedge CLK);
    RST = 1'b0; status_in = 1'b0;
    @(posedge CLK); model_edge(); #1;
    check("rst_status", rd0, 16'h0000);
    repeat (2) cycle("rst_b");

    // randomized traffic
    write_reg("rand_en", 2'd0, 16'h0003);
    repeat (1500) begin
      GWE       = ($urandom_range(0, 9) != 0);
      status_in = $urandom_range(0, 1) == 1;
      irq_ack   = ($urandom_range(0, 7) == 0);
      reg_we    = ($urandom_range(0, 5) == 0);
      reg_re    = $urandom_range(0, 1) == 1;
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = 16'($urandom);
      if (reg_we && reg_addr == 2'd0 && $urandom_range(0, 3) != 0) reg_wdata[0] = 1'b1;
      cycle("rand");
    end

    // long run without clears: 8-bit counter must saturate at 255
    GWE = 1'b1; irq_ack = 1'b0; reg_we = 1'b0; reg_re = 1'b1; reg_addr = 2'd1;
    status_in = 1'b0;
    write_reg("long_ctrl", 2'd0, 16'h0001);
    write_reg("long_clr", 2'd1, 16'h0003);
    status_in = 1'b1;
    repeat (1100) cycle("long");
    check("long_sat0", rd0, 16'hFF03);
    check("long_sat1", rd1, 16'h0303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
